adc_lvds_frame_tx: RTL and testbench

ADC_LVDS_FRAME_TX -- requirements
Module: adc_lvds_frame_tx

---
 rtl/adc_lvds_frame_tx.sv | 122 ++++++++++++
 tb/tb_adc_lvds_frame_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_lvds_frame_tx.sv
// adc_lvds_frame_tx: multi-lane serializer sending DATA_WIDTH-bit frames MSB first with a framing clock.
// Define ADC_TX_TEST_PATTERN_EN to add test_mode and the built-in pattern generator.
module adc_lvds_frame_tx #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 12,
  parameter bit DIN_INVERTED = 1'b0,
  parameter bit FCO_INVERTED = 1'b0
) (
  input  logic                               clk,
  input  logic                               rstn,
`ifdef ADC_TX_TEST_PATTERN_EN
  input  logic [1:0]                         test_mode,
`endif
  input  logic                               tx_en,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  output logic [NUM_CHANNELS-1:0]            dout,
  output logic                               fco,
  output logic                               frame_start,
  output logic                               busy,
  output logic [15:0]                        underrun_cnt
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int TW = NUM_CHANNELS * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] HALF = CW'(DATA_WIDTH / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]           shift_q, shift_d, held_q, held_d, src;
  logic [15:0]             underrun_cnt_q, underrun_cnt_d;
  logic [NUM_CHANNELS-1:0] dout_q, dout_d, lane_msb;
  logic [DATA_WIDTH-1:0]   lane, pat_word;
  logic                    fco_q, fco_d, fs_q, fs_d;
  logic                    boundary, open, hs, load, underrun, pat_on;

`ifdef ADC_TX_TEST_PATTERN_EN
  localparam logic [DATA_WIDTH-1:0] ALT = {(DATA_WIDTH / 2){2'b10}};
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
  logic [DATA_WIDTH-1:0] pat_q, pat_d, pat_idx;
  // Frame index restarts at 0 on every IDLE exit; it drives both ramp value and alternation phase.
  assign pat_on   = test_mode != 2'b00;
  assign pat_idx  = state_q == IDLE ? '0 : pat_q;
  assign pat_word = test_mode == 2'b01 ? pat_idx :
                    test_mode == 2'b10 ? (pat_idx[0] ? ~ALT : ALT) : MID;
  assign pat_d    = (load && pat_on) ? pat_idx + 1'b1 : pat_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pat_q <= '0;
    else       pat_q <= pat_d;
  end
`else
  assign pat_on   = 1'b0;
  assign pat_word = '0;
`endif

  assign boundary     = state_q == RUN && bit_cnt_q == LAST;
  assign open         = tx_en && (state_q == IDLE || boundary);
  assign sample_ready = open && !pat_on;
  assign hs           = sample_ready && sample_valid;
  // At a frame boundary a new frame always starts while enabled: fresh data, pattern or held word.
  assign load         = open && (pat_on || sample_valid || boundary);
  assign underrun     = load && !pat_on && !sample_valid;
  assign src          = pat_on ? {NUM_CHANNELS{pat_word}} : hs ? sample_data : held_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = load ? RUN : (state_q == IDLE || boundary) ? IDLE : RUN;
    bit_cnt_d = (state_d == RUN && !load) ? bit_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    held_d         = hs ? sample_data : held_q;
    underrun_cnt_d = (underrun && underrun_cnt_q != 16'hFFFF) ? underrun_cnt_q + 16'd1 : underrun_cnt_q;
    shift_d        = '0;
    lane_msb       = '0;
    lane           = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      lane = load ? src[i*DATA_WIDTH +: DATA_WIDTH] : shift_q[i*DATA_WIDTH +: DATA_WIDTH];
      lane_msb[i] = lane[DATA_WIDTH-1];
      shift_d[i*DATA_WIDTH +: DATA_WIDTH] = lane << 1;
    end
    dout_d = (state_d == RUN ? lane_msb : '0) ^ {NUM_CHANNELS{DIN_INVERTED}};
    fco_d  = (state_d == RUN && bit_cnt_d < HALF) ^ FCO_INVERTED;
    fs_d   = load;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q        <= '0;
      held_q         <= '0;
      underrun_cnt_q <= '0;
      dout_q         <= {NUM_CHANNELS{DIN_INVERTED}};
      fco_q          <= FCO_INVERTED;
      fs_q           <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      held_q         <= held_d;
      underrun_cnt_q <= underrun_cnt_d;
      dout_q         <= dout_d;
      fco_q          <= fco_d;
      fs_q           <= fs_d;
    end
  end

  assign dout         = dout_q;
  assign fco          = fco_q;
  assign frame_start  = fs_q;
  assign busy         = state_q == RUN;
  assign underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_adc_lvds_frame_tx.sv
// tb_adc_lvds_frame_tx: directed and randomized checks of the serializer against an expected bit-stream queue.
// A second instance with both inversions enabled is checked against the complemented expectation.
module tb_adc_lvds_frame_tx;
  localparam int NC = 4;
  localparam int DW = 12;

  typedef struct packed {
    logic          fs;
    logic          fco;
    logic [NC-1:0] d;
  } ent_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           tx_en = 1'b0;
  logic           sample_valid = 1'b0;
  logic [NC*DW-1:0] sample_data = '0;
  logic           sample_ready, fco, frame_start, busy;
  logic           ready_i, fco_i, fs_i, busy_i;
  logic [NC-1:0]  dout, dout_i;
  logic [15:0]    ucnt, ucnt_i;
`ifdef ADC_TX_TEST_PATTERN_EN
  logic [1:0]     test_mode = 2'b00;
  int             pidx = 0;
`endif

  ent_t           stream[$];
  ent_t           cur = '0;
  bit             running = 1'b0;
  logic [NC*DW-1:0] held = '0;
  logic [15:0]    exp_ucnt = '0;
  logic [DW-1:0]  cap = '0;
  int             nvec = 0;
  int             nerr = 0;

  always #5 clk = ~clk;

  adc_lvds_frame_tx #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
`ifdef ADC_TX_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .tx_en(tx_en), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .dout(dout), .fco(fco), .frame_start(frame_start),
    .busy(busy), .underrun_cnt(ucnt)
  );

  adc_lvds_frame_tx #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .DIN_INVERTED(1'b1), .FCO_INVERTED(1'b1)) dut_inv (
    .clk(clk), .rstn(rstn),
`ifdef ADC_TX_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .tx_en(tx_en), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(ready_i), .dout(dout_i), .fco(fco_i), .frame_start(fs_i),
    .busy(busy_i), .underrun_cnt(ucnt_i)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] rnd();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  // One frame of a word becomes DW expected output cycles, MSB first.
  task automatic push(input logic [NC*DW-1:0] w);
    ent_t e;
    for (int b = DW - 1; b >= 0; b--) begin
      for (int c = 0; c < NC; c++) e.d[c] = w[c*DW+b];
      e.fco = b >= DW / 2;
      e.fs  = b == DW - 1;
      stream.push_back(e);
    end
  endtask

  task automatic check_out();
    logic [NC-1:0] nd;
    logic          nf;
    nd = ~cur.d;
    nf = ~cur.fco;
    chk("dout", dout, cur.d);
    chk("fco", fco, cur.fco);
    chk("frame_start", frame_start, cur.fs);
    chk("busy", busy, running);
    chk("underrun_cnt", ucnt, exp_ucnt);
    chk("dout_inv", dout_i, nd);
    chk("fco_inv", fco_i, nf);
    chk("frame_start_inv", fs_i, cur.fs);
    chk("busy_inv", busy_i, running);
  endtask

  task automatic step(input logic en, input logic v, input logic [NC*DW-1:0] w, output bit acc);
    bit open, pat, rdy;
    logic [DW-1:0] pw;
    tx_en = en;
    sample_valid = v;
    sample_data = w;
    #1;
    open = en && (!running || stream.size() == 0);
    pat = 1'b0;
`ifdef ADC_TX_TEST_PATTERN_EN
    pat = test_mode != 2'b00;
`endif
    rdy = open && !pat;
    acc = rdy && v;
    chk("sample_ready", sample_ready, rdy);
    chk("sample_ready_inv", ready_i, rdy);
    pw = '0;
    if (acc) begin
      held = w;
      push(w);
    end else if (open && pat) begin
`ifdef ADC_TX_TEST_PATTERN_EN
      if (!running) pidx = 0;
      pw = test_mode == 2'b01 ? DW'(pidx) : test_mode == 2'b10 ? ((pidx % 2) ? 12'h555 : 12'hAAA) : 12'h800;
      pidx = (pidx + 1) % (1 << DW);
`endif
      push({NC{pw}});
    end else if (open && running) begin
      push(held);
      if (exp_ucnt != 16'hFFFF) exp_ucnt++;
    end
    @(negedge clk);
    running = stream.size() != 0;
    if (running) cur = stream.pop_front();
    else cur = '0;
    cap = {cap[DW-2:0], dout[0]};
    check_out();
  endtask

  initial begin
    bit acc;
    logic [NC*DW-1:0] w [3];
    int k, g;
    repeat (2) @(negedge clk);
    #1;
    check_out();
    chk("ready_in_reset", sample_ready, 1'b0);
    rstn = 1'b1;

    repeat (3) step(1'b1, 1'b0, '0, acc);

    step(1'b1, 1'b1, 48'h0000_0000_0A5C, acc);
    repeat (11) step(1'b0, 1'b0, '0, acc);
    chk("single_frame_bits", cap, 12'hA5C);
    step(1'b0, 1'b0, '0, acc);
    chk("idle_after_frame", busy, 1'b0);

    for (int i = 0; i < 3; i++) w[i] = rnd();
    k = 0;
    g = 0;
    while (k < 3 && g < 100) begin
      step(1'b1, 1'b1, w[k], acc);
      if (acc) k++;
      g++;
    end
    chk("b2b_accepted", k, 3);
    repeat (13) step(1'b0, 1'b0, '0, acc);
    chk("b2b_no_underrun", ucnt, 16'd0);

    step(1'b1, 1'b1, rnd(), acc);
    repeat (35) step(1'b1, 1'b0, '0, acc);
    repeat (13) step(1'b0, 1'b0, '0, acc);
    chk("underrun_two", ucnt, 16'd2);

    step(1'b1, 1'b1, rnd(), acc);
    repeat (3) step(1'b1, 1'b0, '0, acc);
    force dut.underrun_cnt_q = 16'hFFFD;
    #1;
    release dut.underrun_cnt_q;
    exp_ucnt = 16'hFFFD;
    repeat (40) step(1'b1, 1'b0, '0, acc);
    chk("underrun_saturate", ucnt, 16'hFFFF);
    repeat (13) step(1'b0, 1'b0, '0, acc);

    step(1'b1, 1'b1, rnd(), acc);
    repeat (6) step(1'b0, 1'b0, '0, acc);
    rstn = 1'b0;
    #1;
    stream.delete();
    running = 1'b0;
    cur = '0;
    held = '0;
    exp_ucnt = '0;
    check_out();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) step(1'b0, 1'b0, '0, acc);
    repeat (5) step(1'b1, 1'b0, rnd(), acc);
    step(1'b1, 1'b1, rnd(), acc);
    repeat (13) step(1'b0, 1'b0, '0, acc);

    repeat (800) step(1'($urandom_range(9) != 0), 1'($urandom_range(3) != 0), rnd(), acc);
    repeat (13) step(1'b0, 1'b0, '0, acc);

`ifdef ADC_TX_TEST_PATTERN_EN
    test_mode = 2'b01;
    repeat (12 * 4097) step(1'b1, 1'b1, rnd(), acc);
    chk("ramp_wraps_to_zero", cap, 12'h000);
    repeat (13) step(1'b0, 1'b0, '0, acc);
    test_mode = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
